// File: rtl/mux_arbiter_rr.sv
// ---------------------------------------------------------------------------
// mux_arbiter_rr
//
// Round-robin controller for a shared 2:1 data mux and output register.
// Two requesters compete for one registered output channel with a
// valid/ready handshake toward downstream logic. While both are asking,
// a requester keeps ownership for at most BURST consecutive grants
// before the other one is served.
//
// Parameters:
//   DATA_WIDTH  width of dataIn0, dataIn1, dataOut
//   BURST       max consecutive grants to one requester under contention (1..15)
//   CNT_WIDTH   width of the grant counters (MUX_ARB_CNT_EN builds only)
//
// Ports:
//   clk         system clock, rising edge
//   reset_L     asynchronous active-low reset
//   req0/1      requester has valid data on dataIn0/1
//   dataIn0/1   requester data
//   out_ready   downstream accepts dataOut this cycle
//   grant0/1    pulse: the matching dataIn is captured at the coming edge
//   selector    combinational mux select (0 = dataIn0, 1 = dataIn1)
//   dataOut     registered output data
//   valid_out   dataOut holds an untransferred word
//   src_out     id of the requester whose word is in dataOut
//
// Optional feature (macro MUX_ARB_CNT_EN):
//   cnt_clr     synchronous clear of both grant counters (wins over increment)
//   cnt0/1      saturating counts of grant0/grant1 pulses
// ---------------------------------------------------------------------------
module mux_arbiter_rr #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 2
`ifdef MUX_ARB_CNT_EN
    ,
    parameter int CNT_WIDTH  = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] dataIn0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] dataIn1,
    input  logic                  out_ready,
    output logic                  grant0,
    output logic                  grant1,
    output logic                  selector,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  valid_out,
    output logic                  src_out
`ifdef MUX_ARB_CNT_EN
    ,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  cnt0,
    output logic [CNT_WIDTH-1:0]  cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_L = 4'(BURST);

    state_t                  r_state;
    logic                    r_last;
    logic [3:0]              r_burst;
    logic                    r_sel;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_src;

    logic                    w_any;
    logic                    w_win;
    logic                    w_cap_en;
    logic                    w_same_owner;
    logic [3:0]              w_burst_inc;
    logic [DATA_WIDTH-1:0]   w_mux_data;

    // Winner selection. With no request the select simply holds.
    always_comb begin
        w_win = r_sel;
        if (req0 && !req1) begin
            w_win = 1'b0;
        end else if (req1 && !req0) begin
            w_win = 1'b1;
        end else if (req0 && req1) begin
            case (r_state)
                ST_OWN0: w_win = (r_burst < BURST_L) ? 1'b0 : 1'b1;
                ST_OWN1: w_win = (r_burst < BURST_L) ? 1'b1 : 1'b0;
                default: w_win = ~r_last;
            endcase
        end
    end

    assign w_any        = req0 | req1;
    assign w_cap_en     = (~r_valid | out_ready) & w_any;
    assign w_same_owner = w_win ? (r_state == ST_OWN1) : (r_state == ST_OWN0);
    // Uncontended runs can exceed BURST; clamping keeps the counter from
    // wrapping and handing the owner a fresh burst later.
    assign w_burst_inc  = (r_burst >= BURST_L) ? BURST_L : r_burst + 4'd1;
    assign w_mux_data   = w_win ? dataIn1 : dataIn0;

    // Grants are gated by reset_L so they drop the instant reset asserts.
    assign grant0    = reset_L & w_cap_en & ~w_win;
    assign grant1    = reset_L & w_cap_en &  w_win;
    assign selector  = w_win;
    assign dataOut   = r_data;
    assign valid_out = r_valid;
    assign src_out   = r_src;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_burst <= 4'd0;
            r_sel   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_src   <= 1'b0;
        end else begin
            r_sel <= w_win;
            if (w_cap_en) begin
                // Capture also covers the simultaneous drain: the old word
                // leaves while the new one lands, no bubble.
                r_data  <= w_mux_data;
                r_src   <= w_win;
                r_valid <= 1'b1;
                r_last  <= w_win;
                r_state <= w_win ? ST_OWN1 : ST_OWN0;
                r_burst <= w_same_owner ? w_burst_inc : 4'd1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
                r_state <= ST_IDLE;
                r_burst <= 4'd0;
            end
        end
    end

`ifdef MUX_ARB_CNT_EN
    logic [1:0]                 w_grant;
    logic [1:0][CNT_WIDTH-1:0]  w_cnt;

    assign w_grant = {grant1, grant0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    r_cnt <= '0;
                end else if (cnt_clr) begin
                    r_cnt <= '0;
                end else if (w_grant[gi] && (r_cnt != {CNT_WIDTH{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end

            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign cnt0 = w_cnt[0];
    assign cnt1 = w_cnt[1];
`endif

endmodule

// File: tb/tb_mux_arbiter_rr.sv
module tb_mux_arbiter_rr;

    localparam int DW    = 8;
    localparam int BURST = 2;
`ifdef MUX_ARB_CNT_EN
    localparam int CNTW  = 2;
    localparam int CMAX  = (1 << CNTW) - 1;
`endif

    logic          clk = 1'b0;
    logic          reset_L;
    logic          req0, req1, out_ready;
    logic [DW-1:0] dataIn0, dataIn1;
    logic          grant0, grant1, selector, valid_out, src_out;
    logic [DW-1:0] dataOut;
`ifdef MUX_ARB_CNT_EN
    logic            cnt_clr;
    logic [CNTW-1:0] cnt0, cnt1;
`endif

    always #5 clk = ~clk;

    mux_arbiter_rr #(
        .DATA_WIDTH (DW),
        .BURST      (BURST)
`ifdef MUX_ARB_CNT_EN
        ,
        .CNT_WIDTH  (CNTW)
`endif
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .req0      (req0),
        .dataIn0   (dataIn0),
        .req1      (req1),
        .dataIn1   (dataIn1),
        .out_ready (out_ready),
        .grant0    (grant0),
        .grant1    (grant1),
        .selector  (selector),
        .dataOut   (dataOut),
        .valid_out (valid_out),
        .src_out   (src_out)
`ifdef MUX_ARB_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: who owns the channel, how long the current run is,
    // and what the output register should hold.
    int          m_owner;     // -1 = nobody
    int          m_streak;
    int          m_last;
    logic        m_sel;
    logic        m_valid;
    logic [DW-1:0] m_data;
    logic        m_src;
    int          m_cnt [2];

    int          obs_win;     // observed grant in the last step (-1 = none)

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_streak = 0;
        m_last   = 1;
        m_sel    = 1'b0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_src    = 1'b0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; dataIn0 = '0; dataIn1 = '0; out_ready = 0;
`ifdef MUX_ARB_CNT_EN
        cnt_clr = 0;
`endif
        reset_L = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    // One clock cycle: drive inputs after the falling edge, check every
    // output against the model, then advance the model across the next edge.
    task automatic step(input logic r0, input logic [DW-1:0] d0,
                        input logic r1, input logic [DW-1:0] d1, input logic rdy);
        int win;
        bit cap;
        @(negedge clk);
        req0 = r0; dataIn0 = d0; req1 = r1; dataIn1 = d1; out_ready = rdy;
        #1;
        cyc++;
        if (r0 && !r1)       win = 0;
        else if (r1 && !r0)  win = 1;
        else if (r0 && r1) begin
            if (m_owner < 0)              win = 1 - m_last;
            else if (m_streak < BURST)    win = m_owner;
            else                          win = 1 - m_owner;
        end else             win = int'(m_sel);
        cap = (!m_valid || rdy) && (r0 || r1);

        obs_win = grant1 ? 1 : (grant0 ? 0 : -1);
        check_val("selector", selector, win[0]);
        check_val("grant0",   grant0,   cap && win == 0);
        check_val("grant1",   grant1,   cap && win == 1);
        check_val("valid",    valid_out, m_valid);
        check_val("data",     dataOut,  m_data);
        check_val("src",      src_out,  m_src);
`ifdef MUX_ARB_CNT_EN
        check_val("cnt0", cnt0, m_cnt[0]);
        check_val("cnt1", cnt1, m_cnt[1]);
        if (cnt_clr) begin
            m_cnt[0] = 0;
            m_cnt[1] = 0;
        end else if (cap && m_cnt[win] < CMAX) begin
            m_cnt[win]++;
        end
`endif
        if (cap) begin
            $display("xfer cyc=%0d src=%0d data=%02h", cyc, win, win ? d1 : d0);
            m_data  = win ? d1 : d0;
            m_src   = win[0];
            m_valid = 1'b1;
            m_streak = (m_owner == win) ? m_streak + 1 : 1;
            m_owner = win;
            m_last  = win;
        end else if (m_valid && rdy) begin
            m_valid  = 1'b0;
            m_owner  = -1;
            m_streak = 0;
        end
        m_sel = win[0];
    endtask

    initial begin
        int exp_seq [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

        do_reset();
        // Reset state
        #1;
        check_val("rst_valid", valid_out, 0);
        check_val("rst_data",  dataOut,   0);
        check_val("rst_src",   src_out,   0);

        // Single requester
        step(1, 8'h3C, 0, 8'h00, 1);
        check_val("single_grant0", obs_win, 0);
        step(0, 8'h00, 0, 8'h00, 1);
        check_val("single_data", dataOut, 8'h3C);
        check_val("single_valid", valid_out, 1);

        // Both requesting: BURST grants each in turn
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(i), 1, 8'(8'h80 + i), 1);
            check_val("fair_seq", obs_win, exp_seq[i]);
        end

        // Backpressure then release
        do_reset();
        step(1, 8'h11, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1, 8'h22, 0);
            check_val("bp_nogrant", obs_win, 32'hFFFF_FFFF);
            check_val("bp_hold", dataOut, 8'h11);
        end
        step(0, 8'h00, 1, 8'h22, 1);
        check_val("bp_release_grant1", obs_win, 1);
        step(0, 8'h00, 0, 8'h00, 1);
        check_val("bp_b2b_data", dataOut, 8'h22);

        // Idle return, then opposite-of-last wins
        do_reset();
        step(1, 8'h44, 0, 8'h00, 1);
        step(0, 8'h00, 0, 8'h00, 1);
        step(0, 8'h00, 0, 8'h00, 1);
        check_val("idle_valid", valid_out, 0);
        step(1, 8'h55, 1, 8'h66, 1);
        check_val("idle_opposite", obs_win, 1);

        // Asynchronous reset mid-transfer
        do_reset();
        step(1, 8'hA5, 0, 8'h00, 0);
        step(1, 8'h5A, 0, 8'h00, 0);
        check_val("pre_rst_data", dataOut, 8'hA5);
        #2;
        reset_L = 1'b0;
        #1;
        check_val("arst_data",  dataOut,   0);
        check_val("arst_valid", valid_out, 0);
        check_val("arst_src",   src_out,   0);
        check_val("arst_grant", {grant1, grant0}, 0);
        do_reset();

`ifdef MUX_ARB_CNT_EN
        for (int i = 0; i < 5; i++) step(1, 8'(i), 0, 8'h00, 1);
        step(0, 8'h00, 0, 8'h00, 1);
        check_val("cnt0_sat", cnt0, CMAX);
        cnt_clr = 1'b1;
        step(0, 8'h00, 0, 8'h00, 1);
        cnt_clr = 1'b0;
        step(0, 8'h00, 0, 8'h00, 1);
        check_val("cnt0_clr", cnt0, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
`ifdef MUX_ARB_CNT_EN
            cnt_clr = ($urandom_range(0, 19) == 0);
`endif
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_rr.md
Name: mux_arbiter_rr

Overview:
- Round-robin controller that shares the 2:1 data mux and its output flop between two requesters.
- Each cycle, decides which source the mux selects and when the flop captures it.
- Presents one registered output channel with a valid/ready handshake toward downstream logic.
- Sits between the two data producers and the shared MUX/FLOP datapath.

Parameters:
- DATA_WIDTH, 8: width of dataIn0, dataIn1, dataOut.
- BURST, 2: maximum consecutive grants to one requester while the other is also requesting; legal range 1..15.
- CNT_WIDTH, 8: width of the grant counters (optional feature only).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 has valid data on dataIn0.
- dataIn0  in  DATA_WIDTH  requester 0 data.
- req1  in  1  requester 1 has valid data on dataIn1.
- dataIn1  in  DATA_WIDTH  requester 1 data.
- out_ready  in  1  downstream accepts dataOut this cycle.
- grant0  out  1  one-cycle pulse: dataIn0 captured at this edge.
- grant1  out  1  one-cycle pulse: dataIn1 captured at this edge.
- selector  out  1  combinational mux select for the current cycle (0 = dataIn0, 1 = dataIn1).
- dataOut  out  DATA_WIDTH  registered output data.
- valid_out  out  1  dataOut holds an untransferred word.
- src_out  out  1  registered id of the requester whose word is in dataOut.

Behaviour:
- Reset (reset_L low, asynchronous, also mid-operation), all outputs and state cleared immediately:
  - dataOut=0, valid_out=0, src_out=0, grant0=0, grant1=0.
  - FSM=IDLE, last pointer=1, burst counter=0.
  - Any word held in the output register is discarded.
- Capture enable: cap_en = (!valid_out || out_ready) && (req0 || req1).
- FSM states:
  - IDLE: no owner.
  - OWN0: requester 0 served last.
  - OWN1: requester 1 served last.
- Winner selection, evaluated combinationally each cycle:
  - Only one request asserted: that requester wins.
  - Both asserted, state IDLE: the winner is the requester != last pointer.
  - Both asserted, in OWNx with burst counter < BURST: x wins.
  - Both asserted, in OWNx with burst counter == BURST: the other requester wins.
  - selector = winner; it holds its previous value when there is no request.
- On an edge with cap_en:
  - dataOut <= selected input; src_out <= winner; valid_out <= 1.
  - grant<winner> pulses high for exactly that cycle.
  - FSM -> OWN<winner>, last pointer <= winner.
  - Burst counter <= counter+1 if the winner equals the previous owner, otherwise 1.
- Edge with out_ready && valid_out and no capture: valid_out <= 0, FSM -> IDLE, burst counter <= 0; last pointer retained.
- Edge with valid_out && !out_ready: dataOut, src_out, valid_out held; no grant; selector still updates; FSM unchanged.
- Simultaneous drain and capture: back-to-back transfer, with no bubble and no lost word.
- Latency and throughput:
  - One cycle from request with cap_en to valid_out.
  - Throughput is 1 word/clk while out_ready=1.
- Fairness: with both requesters continuously asserting, the grant pattern is BURST grants to one, then BURST to the other.
- Requesters hold req and data until their grant pulse; a req drop before grant is legal and is simply not served.
- grant0 and grant1 are never high in the same cycle.

Optional Feature:
- Macro: MUX_ARB_CNT_EN.
- Defined:
  - Adds outputs cnt0 and cnt1 (CNT_WIDTH each) counting grant0 and grant1 pulses.
  - Counters saturate at all-ones, clear on reset_L, and clear synchronously when input cnt_clr=1 (cnt_clr also added).
  - cnt_clr has priority over an increment in the same cycle.
- Undefined: no counter ports or logic; behaviour otherwise identical.

Test Plan:
- Reset: assert reset_L=0 mid-transfer with valid_out=1, dataOut=8'hA5 -> all outputs 0 immediately, without waiting for a clock edge.
- Single requester: req0=1, dataIn0=8'h3C, out_ready=1 -> grant0 pulse; next cycle dataOut=8'h3C, valid_out=1, src_out=0.
- Both requesting, BURST=2, out_ready=1, 8 cycles -> grant sequence 0,0,1,1,0,0,1,1.
- Backpressure: valid_out=1, out_ready=0 for 3 cycles with req1=1 -> dataOut unchanged, no grant1; out_ready=1 -> grant1 on that edge and back-to-back capture.
- Idle return: single transfer then no requests -> valid_out falls after out_ready, FSM IDLE; next simultaneous request is won by the requester opposite last pointer.
- MUX_ARB_CNT_EN defined, CNT_WIDTH=2: 5 grants to requester 0 -> cnt0 saturates at 3; cnt_clr=1 -> cnt0=0 next cycle.
